// File: rtl/datapath_sequencer_if.sv
// ============================================================================
// Module   : datapath_sequencer_if
// Brief    : Command handshake and datapath control-word bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface datapath_sequencer_if #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_op;
  logic [3:0]            cmd_rd;
  logic [3:0]            cmd_ra;
  logic [3:0]            cmd_rb;
  logic [DATA_WIDTH-1:0] cmd_imm;

  logic [NUM_REGS-1:0]   register_select;
  logic [DATA_WIDTH-1:0] register_set;
  logic [3:0]            read_select;
  logic                  bus_from_reg;
  logic                  bus_from_z;
  logic                  bus_from_imm;
  logic                  y_load;
  logic                  z_load;
  logic [3:0]            op_select;

  // Command source / datapath side.
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    input  cmd_ready,
    input  register_select, register_set, read_select,
    input  bus_from_reg, bus_from_z, bus_from_imm,
    input  y_load, z_load, op_select
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm,
    output cmd_ready,
    output register_select, register_set, read_select,
    output bus_from_reg, bus_from_z, bus_from_imm,
    output y_load, z_load, op_select
  );
endinterface

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// ============================================================================
// Module   : datapath_sequencer
// Brief    : Issues per-cycle datapath control words for LOADI / ALU commands.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datapath_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic            clock,
  input  wire logic            clear,
  datapath_sequencer_if.slave  bus_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          retired_count_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDI  = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4
  } state_e;

  localparam logic [3:0] C_OP_LOADI = 4'b0000;

  state_e                state_q, state_d;
  logic [3:0]            op_q, rd_q, ra_q, rb_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic                  done_q;
  logic [15:0]           count_q;

  logic                  w_idle;
  logic                  w_accept;
  logic                  w_retire;
  logic [NUM_REGS-1:0]   w_rd_onehot;

  assign w_idle      = (state_q == S_IDLE);
  assign w_accept    = w_idle && bus_if.cmd_valid;
  assign w_retire    = (state_q == S_LDI) || (state_q == S_T3);
  assign w_rd_onehot = NUM_REGS'(1) << rd_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      imm_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= w_retire;
      if (w_retire) begin
        count_q <= count_q + 16'd1;
      end
      if (w_accept) begin
        op_q  <= bus_if.cmd_op;
        rd_q  <= bus_if.cmd_rd;
        ra_q  <= bus_if.cmd_ra;
        rb_q  <= bus_if.cmd_rb;
        imm_q <= bus_if.cmd_imm;
      end
    end
  end

  // Control outputs depend only on state_q and the latched command.
  always_comb begin
    state_d                = state_q;
    bus_if.register_select = '0;
    bus_if.register_set    = '0;
    bus_if.read_select     = '0;
    bus_if.bus_from_reg    = 1'b0;
    bus_if.bus_from_z      = 1'b0;
    bus_if.bus_from_imm    = 1'b0;
    bus_if.y_load          = 1'b0;
    bus_if.z_load          = 1'b0;
    bus_if.op_select       = '0;
    case (state_q)
      S_IDLE: begin
        if (bus_if.cmd_valid) begin
          state_d = (bus_if.cmd_op == C_OP_LOADI) ? S_LDI : S_T1;
        end
      end
      S_LDI: begin
        bus_if.bus_from_imm    = 1'b1;
        bus_if.register_set    = imm_q;
        bus_if.register_select = w_rd_onehot;
        state_d                = S_IDLE;
      end
      S_T1: begin
        bus_if.bus_from_reg = 1'b1;
        bus_if.read_select  = ra_q;
        bus_if.y_load       = 1'b1;
        state_d             = S_T2;
      end
      S_T2: begin
        bus_if.bus_from_reg = 1'b1;
        bus_if.read_select  = rb_q;
        bus_if.op_select    = op_q;
        bus_if.z_load       = 1'b1;
        state_d             = S_T3;
      end
      S_T3: begin
        bus_if.bus_from_z      = 1'b1;
        bus_if.register_select = w_rd_onehot;
        state_d                = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.cmd_ready = w_idle;
  assign busy_o           = !w_idle;
  assign done_o           = done_q;
  assign retired_count_o  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
// Module   : tb_datapath_sequencer
// Brief    : Schedule-based reference model plus directed and random stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        busy;
  logic        done;
  logic [15:0] rcount;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  datapath_sequencer_if #(.NUM_REGS(16), .DATA_WIDTH(32)) dif ();

  datapath_sequencer #(.NUM_REGS(16), .DATA_WIDTH(32)) dut (
    .clock           (clock),
    .clear           (clear),
    .bus_if          (dif.slave),
    .busy_o          (busy),
    .done_o          (done),
    .retired_count_o (rcount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  // Each command expands into the list of cycles it will occupy, followed by
  // the idle cycle that carries its done pulse.
  typedef struct packed {
    logic        busy;
    logic [15:0] rsel;
    logic [31:0] rset;
    logic [3:0]  rdsel;
    logic        bfr;
    logic        bfz;
    logic        bfi;
    logic        yl;
    logic        zl;
    logic [3:0]  op;
    logic        done;
  } exp_t;

  exp_t        cur = '0;
  exp_t        sched[$];
  logic [15:0] m_count = '0;

  function automatic void plan(logic [3:0] op, logic [3:0] rd, logic [3:0] ra,
                               logic [3:0] rb, logic [31:0] imm);
    exp_t        r;
    logic [15:0] oh;
    oh = 16'h1 << rd;
    if (op == 4'd0) begin
      r = '0; r.busy = 1'b1; r.bfi = 1'b1; r.rset = imm; r.rsel = oh;
      sched.push_back(r);
    end else begin
      r = '0; r.busy = 1'b1; r.bfr = 1'b1; r.rdsel = ra; r.yl = 1'b1;
      sched.push_back(r);
      r = '0; r.busy = 1'b1; r.bfr = 1'b1; r.rdsel = rb; r.op = op; r.zl = 1'b1;
      sched.push_back(r);
      r = '0; r.busy = 1'b1; r.bfz = 1'b1; r.rsel = oh;
      sched.push_back(r);
    end
    r = '0; r.done = 1'b1;
    sched.push_back(r);
  endfunction

  always @(posedge clock) begin
    if (clear) begin
      sched.delete();
      cur     = '0;
      m_count = '0;
    end else begin
      if (!cur.busy && dif.cmd_valid)
        plan(dif.cmd_op, dif.cmd_rd, dif.cmd_ra, dif.cmd_rb, dif.cmd_imm);
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = '0;
      if (cur.done) m_count = m_count + 16'd1;
    end
  end

  always @(negedge clock) begin
    chk("cmd_ready",       dif.cmd_ready,       !cur.busy);
    chk("busy",            busy,                cur.busy);
    chk("register_select", dif.register_select, cur.rsel);
    chk("register_set",    dif.register_set,    cur.rset);
    chk("read_select",     dif.read_select,     cur.rdsel);
    chk("bus_from_reg",    dif.bus_from_reg,    cur.bfr);
    chk("bus_from_z",      dif.bus_from_z,      cur.bfz);
    chk("bus_from_imm",    dif.bus_from_imm,    cur.bfi);
    chk("y_load",          dif.y_load,          cur.yl);
    chk("z_load",          dif.z_load,          cur.zl);
    chk("op_select",       dif.op_select,       cur.op);
    chk("done",            done,                cur.done);
    chk("retired_count",   rcount,              m_count);
  end

  // Entered at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [31:0] imm, input bit hold, output int acc);
    int n;
    n = 0;
    dif.cmd_valid = 1'b1;
    dif.cmd_op = op; dif.cmd_rd = rd; dif.cmd_ra = ra; dif.cmd_rb = rb;
    dif.cmd_imm = imm;
    while (!dif.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!dif.cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clock);
    acc = cyc;
    if (!hold) dif.cmd_valid = 1'b0;
  endtask

  initial begin
    int a0, a1, a2, nd;
    dif.cmd_valid = 1'b0;
    dif.cmd_op = '0; dif.cmd_rd = '0; dif.cmd_ra = '0; dif.cmd_rb = '0;
    dif.cmd_imm = '0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    chk("rst_ready", dif.cmd_ready, 1);
    chk("rst_rsel", dif.register_select, 0);
    chk("rst_count", rcount, 0);

    // LOADI rd=0 imm=5
    issue(4'd0, 4'd0, 4'd0, 4'd0, 32'd5, 1'b0, a0);
    chk("ldi_rsel", dif.register_select, 32'h0001);
    chk("ldi_rset", dif.register_set, 5);
    chk("ldi_bfi", dif.bus_from_imm, 1);
    @(negedge clock);
    chk("ldi_done", done, 1);
    chk("ldi_count", rcount, 1);

    // LOADI rd=1 imm=1 then ADD-style op 3: rd=2 ra=0 rb=1
    issue(4'd0, 4'd1, 4'd0, 4'd0, 32'd1, 1'b0, a0);
    issue(4'd3, 4'd2, 4'd0, 4'd1, 32'd0, 1'b0, a1);
    chk("t1_rdsel", dif.read_select, 0);
    chk("t1_yload", dif.y_load, 1);
    @(negedge clock);
    chk("t2_rdsel", dif.read_select, 1);
    chk("t2_op", dif.op_select, 3);
    chk("t2_zload", dif.z_load, 1);
    @(negedge clock);
    chk("t3_bfz", dif.bus_from_z, 1);
    chk("t3_rsel", dif.register_select, 32'h0004);
    @(negedge clock);
    chk("alu_done", done, 1);

    // Clear in the middle of T2: rd=7 must never be written
    issue(4'd5, 4'd7, 4'd2, 4'd3, 32'd0, 1'b0, a0);
    @(negedge clock);
    chk("mid_t2_zload", dif.z_load, 1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_rsel", dif.register_select, 0);
    chk("clr_count", rcount, 0);
    repeat (4) begin
      @(negedge clock);
      chk("clr_no_write", dif.register_select[7], 0);
    end

    // Three ALU commands behind a held-high valid
    issue(4'd2, 4'd1, 4'd2, 4'd3, 32'd0, 1'b1, a0);
    issue(4'd4, 4'd4, 4'd5, 4'd6, 32'd0, 1'b1, a1);
    issue(4'd6, 4'd7, 4'd8, 4'd9, 32'd0, 1'b0, a2);
    chk("held_gap1", a1 - a0, 4);
    chk("held_gap2", a2 - a1, 4);
    repeat (3) @(negedge clock);
    chk("held_count", rcount, 3);

    // Fields toggling while busy are ignored
    issue(4'h9, 4'd3, 4'd4, 4'd6, 32'd0, 1'b0, a0);
    repeat (2) begin
      dif.cmd_op = 4'($urandom); dif.cmd_rd = 4'($urandom);
      @(negedge clock);
    end
    chk("tog_rsel", dif.register_select, 32'h0008);
    dif.cmd_op = 4'($urandom); dif.cmd_rd = 4'($urandom);
    @(negedge clock);

    // rd = ra = rb = 5
    issue(4'd1, 4'd5, 4'd5, 4'd5, 32'd0, 1'b0, a0);
    chk("same_t1", dif.read_select, 5);
    @(negedge clock);
    chk("same_t2", dif.read_select, 5);
    @(negedge clock);
    chk("same_t3", dif.register_select, 32'h0020);
    nd = 0;
    repeat (5) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("same_done_pulses", nd, 1);

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      dif.cmd_valid = ($urandom_range(0, 9) < 7);
      dif.cmd_op    = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom);
      dif.cmd_rd    = 4'($urandom);
      dif.cmd_ra    = 4'($urandom);
      dif.cmd_rb    = 4'($urandom);
      dif.cmd_imm   = $urandom;
      clear         = ($urandom_range(0, 39) == 0);
      @(negedge clock);
    end
    clear = 1'b0;
    dif.cmd_valid = 1'b0;
    repeat (6) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
